prbs_checker: RTL and testbench
===============================

Name: prbs_checker

Overview:
- Receive-side counterpart of the team's 5-stage LFSR pattern generator.
- Accepts the serial PRBS bitstream produced by that generator, self-synchronises to it, and reports lock status, per-bit errors and running bit/error counts.
- Sits at the sink end of the serial test path, for link bring-up and BER measurement.

Parameters:
- ORDER, 5: recurrence length; the sequence obeys s[n] = s[n-ORDER] xor s[n-TAP].
- TAP, 3: second tap of the recurrence. Defaults give x^5+x^2+1, period 31.
- LOCK_CNT, 16: consecutive correct predictions needed to declare lock.
- WINDOW, 31: valid bits per loss-of-lock evaluation window.
- LOSS_THRESH, 4: errors within one window that force loss of lock.
- CNT_W, 16: width of the bit and error counters.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset; synchronous, active-low.
- din  input  1  serial PRBS bit under test.
- din_valid  input  1  din is sampled only when this is high.
- clear  input  1  synchronous clear of bit_count and err_count; lock state is unaffected.
- locked  output  1  high in LOCKED state.
- err  output  1  one-cycle pulse: the previous valid bit mismatched the prediction (LOCKED only).
- bit_count  output  CNT_W  valid bits checked while LOCKED; saturates at all-ones.
- err_count  output  CNT_W  errors while LOCKED; saturates at all-ones.

Behaviour:
- Reset (rst=0 at a clk edge): state=SEARCH. History register, fill counter, match counter, window counter and window error counter all 0. locked=0, err=0, bit_count=0, err_count=0. rst takes priority over every other input.
- Cycles with din_valid=0: no state, register or counter changes; err=0.
- History register: ORDER bits. hist[0] is the newest bit; a shift moves every bit up one place.
- Prediction: pred = hist[ORDER-1] xor hist[TAP-1], i.e. s[n-ORDER] xor s[n-TAP].
- SEARCH state:
  - Every valid bit shifts din into the history register.
  - While fill < ORDER: fill increments and no comparison is made.
  - Once full: compare din to pred. On a match, match_cnt increments. On a mismatch, match_cnt=0.
  - When a match makes match_cnt reach LOCK_CNT: go to LOCKED on that edge and set locked=1. Window counters are cleared.
- LOCKED state:
  - The history register is fed with pred, not din. It free-runs, so input errors never corrupt the reference.
  - Each valid bit: bit_count+1. If din != pred: err=1 on the next cycle, err_count+1, win_err+1.
  - win_cnt counts valid bits. When it reaches WINDOW, win_cnt and win_err reset to 0.
  - If win_err reaches LOSS_THRESH on any bit (checked before the window wrap): go to SEARCH. locked=0 on that edge. fill, match_cnt, win_cnt and win_err are cleared. Counters hold their values.
- Latency: err, locked and the counters update on the clk edge that samples the valid bit, so they are visible the cycle after the bit.
- An all-zero history while LOCKED cannot occur from a valid PRBS. If the history shifts to all zeros in SEARCH, a continuous 0 input matches forever. This is not special-cased; it is an accepted lock onto a stuck-0 line and is verified as such.
- Saturation: counters stop at 2^CNT_W-1; err still pulses.
- clear and a counted event on the same edge: clear wins, and the counters become 0. err still pulses.
- Dropping from LOCKED to SEARCH on a window-edge bit: the loss takes precedence over the window wrap.
- Arithmetic is unsigned. There is no wrap anywhere except win_cnt.

Decomposition:
- Shared package prbs_pkg holds:
  - default ORDER/TAP constants;
  - state encoding SEARCH=1'b0, LOCKED=1'b1;
  - LOCK_CNT, WINDOW and LOSS_THRESH defaults.
- One sub-module, prbs_predictor, holds:
  - the ORDER-bit history register, with a load-mux select between din and pred;
  - the combinational pred output.
- The FSM and counters stay in prbs_checker.

Test Plan:
- Reset, then clean generator stream starting 0,1,0,1,1,0,0,1,… with din_valid=1 → locked rises after exactly ORDER+LOCK_CNT=21 valid bits. err stays 0. bit_count=100 after 100 further bits, err_count=0.
- While locked, invert 3 isolated bits within one 31-bit window → three err pulses, err_count=3, locked stays 1.
- While locked, invert 4 bits within one window → err_count=4 and locked falls on the 4th error's edge. With a clean stream afterwards, it relocks after 21 valid bits and err_count still reads 4.
- Toggle din_valid 1/0 every cycle on a clean stream → lock at valid bit 21 (cycle ~42). No errors; bit_count advances only on valid beats.
- Assert clear on the same edge as an injected error → err pulses and both counters read 0 next cycle. Force err_count to near saturation (CNT_W=4 build, 20 errors spread across windows) → it holds at 15.
- Assert rst mid-lock → all outputs 0 the next cycle and state=SEARCH. Reacquisition takes 21 valid bits.

Source files
------------

// File: rtl/prbs_pkg.sv
// prbs_pkg: shared defaults and state encoding for the PRBS checker.
package prbs_pkg;

    localparam int ORDER_DEF       = 5;
    localparam int TAP_DEF         = 3;
    localparam int LOCK_CNT_DEF    = 16;
    localparam int WINDOW_DEF      = 31;
    localparam int LOSS_THRESH_DEF = 4;

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } state_e;

endpackage

// File: rtl/prbs_predictor.sv
// prbs_predictor: history shift register and next-bit prediction for the recurrence.
module prbs_predictor
    import prbs_pkg::*;
#(
    parameter int ORDER = ORDER_DEF,
    parameter int TAP   = TAP_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic shift_i,
    input  logic use_pred_i,
    input  logic din_i,
    output logic pred_o
);

    logic [ORDER-1:0] hist_q, hist_d;

    assign pred_o = hist_q[ORDER-1] ^ hist_q[TAP-1];

    // Shift in either the received bit or the prediction (free-running reference).
    always_comb begin
        hist_d = shift_i ? {hist_q[ORDER-2:0], use_pred_i ? pred_o : din_i} : hist_q;
    end

    // History register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) hist_q <= '0;
        else      hist_q <= hist_d;
    end

endmodule

// File: rtl/prbs_checker.sv
// prbs_checker: self-synchronising PRBS receiver with lock tracking and BER counters.
module prbs_checker
    import prbs_pkg::*;
#(
    parameter int ORDER       = ORDER_DEF,
    parameter int TAP         = TAP_DEF,
    parameter int LOCK_CNT    = LOCK_CNT_DEF,
    parameter int WINDOW      = WINDOW_DEF,
    parameter int LOSS_THRESH = LOSS_THRESH_DEF,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    input  logic             din_valid,
    input  logic             clear,
    output logic             locked,
    output logic             err,
    output logic [CNT_W-1:0] bit_count,
    output logic [CNT_W-1:0] err_count
);

    localparam int FW = $clog2(ORDER + 1);
    localparam int MW = $clog2(LOCK_CNT + 1);
    localparam int WW = $clog2(WINDOW + 1);
    localparam int EW = $clog2(LOSS_THRESH + 1);
    localparam logic [FW-1:0] FILL_FULL = FW'(ORDER);
    localparam logic [MW-1:0] MATCH_MAX = MW'(LOCK_CNT - 1);
    localparam logic [WW-1:0] WIN_LEN   = WW'(WINDOW);
    localparam logic [EW-1:0] LOSS_LIM  = EW'(LOSS_THRESH);

    state_e           state_q, state_d;
    logic [FW-1:0]    fill_q, fill_d;
    logic [MW-1:0]    match_q, match_d;
    logic [WW-1:0]    win_cnt_q, win_cnt_d;
    logic [EW-1:0]    win_err_q, win_err_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic             err_q, err_d;
    logic             pred;
    logic             mis;

    prbs_predictor #(.ORDER(ORDER), .TAP(TAP)) u_pred (
        .clk        (clk),
        .rst        (rst),
        .shift_i    (din_valid),
        .use_pred_i (state_q == LOCKED),
        .din_i      (din),
        .pred_o     (pred)
    );

    assign mis = din != pred;

    // Acquisition, loss-of-lock windowing and saturating counters.
    always_comb begin
        state_d   = state_q;
        fill_d    = fill_q;
        match_d   = match_q;
        win_cnt_d = win_cnt_q;
        win_err_d = win_err_q;
        bit_cnt_d = bit_cnt_q;
        err_cnt_d = err_cnt_q;
        err_d     = 1'b0;
        if (din_valid) begin
            if (state_q == SEARCH) begin
                if (fill_q < FILL_FULL) fill_d = fill_q + 1'b1;
                else if (mis) match_d = '0;
                else if (match_q == MATCH_MAX) begin
                    state_d   = LOCKED;
                    match_d   = '0;
                    win_cnt_d = '0;
                    win_err_d = '0;
                end else match_d = match_q + 1'b1;
            end else begin
                err_d     = mis;
                bit_cnt_d = &bit_cnt_q ? bit_cnt_q : bit_cnt_q + 1'b1;
                err_cnt_d = (mis && !(&err_cnt_q)) ? err_cnt_q + 1'b1 : err_cnt_q;
                win_err_d = win_err_q + EW'(mis);
                win_cnt_d = win_cnt_q + 1'b1;
                if (win_err_d == LOSS_LIM) begin
                    state_d   = SEARCH;
                    fill_d    = '0;
                    match_d   = '0;
                    win_cnt_d = '0;
                    win_err_d = '0;
                end else if (win_cnt_d == WIN_LEN) begin
                    win_cnt_d = '0;
                    win_err_d = '0;
                end
            end
        end
        if (clear) begin
            bit_cnt_d = '0;
            err_cnt_d = '0;
        end
    end

    // State and counter registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= SEARCH;
            fill_q    <= '0;
            match_q   <= '0;
            win_cnt_q <= '0;
            win_err_q <= '0;
            bit_cnt_q <= '0;
            err_cnt_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            fill_q    <= fill_d;
            match_q   <= match_d;
            win_cnt_q <= win_cnt_d;
            win_err_q <= win_err_d;
            bit_cnt_q <= bit_cnt_d;
            err_cnt_q <= err_cnt_d;
            err_q     <= err_d;
        end
    end

    assign locked    = state_q == LOCKED;
    assign err       = err_q;
    assign bit_count = bit_cnt_q;
    assign err_count = err_cnt_q;

endmodule

// File: tb/tb_prbs_checker.sv
// tb_prbs_checker: directed and randomized checks of prbs_checker against a stream-level model.
module tb_prbs_checker;

    localparam int ORDER       = 5;
    localparam int TAP         = 3;
    localparam int LOCK_CNT    = 16;
    localparam int WINDOW      = 31;
    localparam int LOSS_THRESH = 4;

    logic        clk = 1'b0;
    logic        rst, din, din_valid, clear;
    logic        locked, err, locked4, err4;
    logic [15:0] bit_count, err_count;
    logic [3:0]  bit_count4, err_count4;

    int tests = 0;
    int fails = 0;

    bit g[$] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    int gi = 0;

    bit mh[$];
    bit m_locked, m_err;
    int m_fill, m_match, m_wcnt, m_werr, mb, me;

    always #5 clk = ~clk;

    prbs_checker #(.CNT_W(16)) dut (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .clear(clear),
        .locked(locked), .err(err), .bit_count(bit_count), .err_count(err_count)
    );

    prbs_checker #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .clear(clear),
        .locked(locked4), .err(err4), .bit_count(bit_count4), .err_count(err_count4)
    );

    function automatic bit gen_next();
        if (gi >= g.size()) g.push_back(g[gi-ORDER] ^ g[gi-TAP]);
        gen_next = g[gi];
        gi++;
    endfunction

    function automatic int sat(input int x, input int w);
        int m;
        m = (1 << w) - 1;
        return x > m ? m : x;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: the stream obeys s[n]=s[n-ORDER]^s[n-TAP]; mh holds recent bits, newest first.
    task automatic model(input logic d, input logic v, input logic c);
        bit p, e;
        e = 1'b0;
        if (!rst) begin
            mh = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
            m_locked = 1'b0;
            m_fill = 0; m_match = 0; m_wcnt = 0; m_werr = 0; mb = 0; me = 0;
        end else begin
            if (v) begin
                p = mh[ORDER-1] ^ mh[TAP-1];
                if (!m_locked) begin
                    mh.push_front(d);
                    void'(mh.pop_back());
                    if (m_fill < ORDER) m_fill++;
                    else if (d == p) begin
                        m_match++;
                        if (m_match == LOCK_CNT) begin
                            m_locked = 1'b1; m_match = 0; m_wcnt = 0; m_werr = 0;
                        end
                    end else m_match = 0;
                end else begin
                    mh.push_front(p);
                    void'(mh.pop_back());
                    mb++;
                    if (d != p) begin e = 1'b1; me++; m_werr++; end
                    m_wcnt++;
                    if (m_werr == LOSS_THRESH) begin
                        m_locked = 1'b0; m_fill = 0; m_match = 0; m_wcnt = 0; m_werr = 0;
                    end else if (m_wcnt == WINDOW) begin
                        m_wcnt = 0; m_werr = 0;
                    end
                end
            end
            if (c) begin mb = 0; me = 0; end
        end
        m_err = e;
    endtask

    task automatic check_all();
        chk("locked", locked, m_locked);
        chk("err", err, m_err);
        chk("bit_count", bit_count, sat(mb, 16));
        chk("err_count", err_count, sat(me, 16));
        chk("locked4", locked4, m_locked);
        chk("err4", err4, m_err);
        chk("bit_count4", bit_count4, sat(mb, 4));
        chk("err_count4", err_count4, sat(me, 4));
    endtask

    task automatic step(input logic d, input logic v, input logic c);
        @(negedge clk);
        din = d; din_valid = v; clear = c;
        @(posedge clk);
        model(d, v, c);
        #1;
        check_all();
    endtask

    task automatic send_bit(input bit flip, input logic c);
        step(gen_next() ^ flip, 1'b1, c);
    endtask

    task automatic clean(input int n);
        repeat (n) send_bit(1'b0, 1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        step(1'b0, 1'b0, 1'b0);
        rst = 1'b1;
    endtask

    task automatic acquire(input string tag);
        int n;
        n = 0;
        while (!locked && n < 100) begin
            send_bit(1'b0, 1'b0);
            n++;
        end
        chk(tag, n, ORDER + LOCK_CNT);
    endtask

    initial begin
        int n, cyc, pulses, k;
        bit v, f, c;
        rst = 1'b0; din = 1'b0; din_valid = 1'b0; clear = 1'b0;
        do_reset();
        do_reset();
        chk("rst_locked", locked, 0);
        chk("rst_bits", bit_count, 0);
        acquire("lock_latency");
        clean(100);
        chk("bits100", bit_count, 100);
        chk("errs0", err_count, 0);
        pulses = 0;
        for (int i = 0; i < 31; i++) begin
            send_bit(i == 2 || i == 9 || i == 16, 1'b0);
            if (err) pulses++;
        end
        chk("three_pulses", pulses, 3);
        chk("three_errs", err_count, 3);
        chk("three_locked", locked, 1);
        step(1'b0, 1'b0, 1'b1);
        k = 0;
        for (int i = 0; i < 8 && locked; i++) begin
            send_bit(i % 2 == 0, 1'b0);
            k++;
        end
        chk("loss_bits", k, 7);
        chk("loss_locked", locked, 0);
        chk("loss_errs", err_count, 4);
        acquire("relock_latency");
        chk("relock_errs", err_count, 4);
        do_reset();
        n = 0;
        cyc = 0;
        while (!locked && cyc < 200) begin
            if (cyc % 2 == 0) begin
                send_bit(1'b0, 1'b0);
                n++;
            end else step(1'($urandom % 2), 1'b0, 1'b0);
            cyc++;
        end
        chk("toggle_lock_bits", n, ORDER + LOCK_CNT);
        chk("toggle_lock_cycles", cyc, 41);
        for (int i = 0; i < 40; i++) begin
            if ((cyc + i) % 2 == 0) send_bit(1'b0, 1'b0);
            else step(1'($urandom % 2), 1'b0, 1'b0);
        end
        chk("toggle_bits", bit_count, 20);
        for (int i = 0; i < 600; i++) begin
            v = ($urandom % 4) != 0;
            f = ($urandom % 50) == 0;
            c = ($urandom % 150) == 0;
            if (v) send_bit(f, c);
            else step(1'($urandom % 2), 1'b0, c);
        end
        do_reset();
        acquire("clear_lock");
        clean(5);
        send_bit(1'b1, 1'b1);
        chk("clear_err_pulse", err, 1);
        chk("clear_bits", bit_count, 0);
        chk("clear_errs", err_count, 0);
        do_reset();
        acquire("sat_lock");
        for (int i = 0; i < 20; i++) begin
            clean(11);
            send_bit(1'b1, 1'b0);
        end
        chk("sat_pulse", err4, 1);
        chk("sat_errs4", err_count4, 15);
        chk("sat_bits4", bit_count4, 15);
        chk("sat_errs16", err_count, 20);
        chk("sat_locked", locked, 1);
        do_reset();
        chk("midrst_locked", locked, 0);
        chk("midrst_err", err, 0);
        chk("midrst_bits", bit_count, 0);
        chk("midrst_errs", err_count, 0);
        acquire("midrst_relock");
        do_reset();
        n = 0;
        while (!locked && n < 100) begin
            step(1'b0, 1'b1, 1'b0);
            n++;
        end
        chk("stuck0_lock", n, ORDER + LOCK_CNT);
        repeat (40) step(1'b0, 1'b1, 1'b0);
        chk("stuck0_bits", bit_count, 40);
        chk("stuck0_errs", err_count, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
